// File: rtl/zpu_mem_bridge.sv
// Bridges ZPU core memory strobes to a 512x8 synchronous ROM (region 0)
// and a small output I/O register (region 1), one access at a time.
module zpu_mem_bridge #(
  parameter int IO_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [9:0]          mem_addr,
  input  logic [31:0]         mem_data_write,
  output logic [31:0]         mem_data_read,
  output logic                mem_done,
  output logic [8:0]          rom_addr,
  output logic                rom_re,
  input  logic [7:0]          rom_data,
  output logic [IO_WIDTH-1:0] io_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROM_RD = 2'd1,
    IO_ACC = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]          cnt;
  logic [2:0]          cap_idx;
  logic [6:0]          base_p0;
  logic                op_write_p0;
  logic                op_io_p0;
  logic [IO_WIDTH-1:0] wdata_p0;
  logic [31:0]         io_ext;
  logic                unused_bits;

  // Word byte lanes are big-endian: byte 0 lands in the top lane.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  assign cap_idx     = cnt - 3'd1;
  assign unused_bits = ^{mem_addr[1:0], mem_data_write};

  always_comb begin
    io_ext                 = '0;
    io_ext[IO_WIDTH-1:0]   = io_out;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_write)                    state_nxt = IO_ACC;
        else if (mem_read && !mem_addr[9]) state_nxt = ROM_RD;
        else if (mem_read)                 state_nxt = IO_ACC;
      end
      ROM_RD:  if (cnt == 3'd4) state_nxt = DONE;
      IO_ACC:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rom_re   = 1'b0;
    rom_addr = '0;
    mem_done = 1'b0;
    if (state == ROM_RD && !cnt[2]) begin
      rom_re   = 1'b1;
      rom_addr = {base_p0, cnt[1:0]};
    end
    if (state == DONE) mem_done = 1'b1;
  end

  // Request capture stage: latched once in IDLE, held for the whole access.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      base_p0     <= mem_addr[8:2];
      op_write_p0 <= mem_write;
      op_io_p0    <= mem_addr[9];
      wdata_p0    <= mem_data_write[IO_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (state == ROM_RD) cnt <= cnt + 3'd1;
    else                      cnt <= '0;
  end

  // Capture stage: ROM bytes arrive one cycle behind their issue slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_read <= '0;
      io_out        <= '0;
    end else begin
      if (state == ROM_RD && cnt != 3'd0)
        mem_data_read <= put_byte(mem_data_read, cap_idx[1:0], rom_data);
      if (state == IO_ACC) begin
        if (!op_write_p0)   mem_data_read <= io_ext;
        else if (op_io_p0)  io_out        <= wdata_p0;
      end
    end
  end

endmodule

// File: tb/tb_zpu_mem_bridge.sv
// Scoreboard bench for zpu_mem_bridge with a behavioural 512x8 synchronous ROM.
module tb_zpu_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_write;
  logic [31:0] mem_data_read;
  logic        mem_done;
  logic [8:0]  rom_addr;
  logic        rom_re;
  logic [7:0]  rom_data;
  logic [4:0]  io_out;

  logic [7:0]  rom [512];
  logic [31:0] exp_q[$];
  logic [31:0] last_read;
  logic [4:0]  io_model;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  zpu_mem_bridge #(.IO_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read), .mem_done(mem_done),
    .rom_addr(rom_addr), .rom_re(rom_re), .rom_data(rom_data), .io_out(io_out)
  );

  always @(posedge clk) if (rom_re) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [6:0] base);
    return {rom[{base, 2'd0}], rom[{base, 2'd1}], rom[{base, 2'd2}], rom[{base, 2'd3}]};
  endfunction

  // Starts in a fresh IDLE cycle (just after a rising edge), ends the same way.
  task automatic access(input bit rd, input bit wr, input logic [9:0] addr,
                        input logic [31:0] wd);
    bit          rom_rd;
    bit          re_seen;
    int          lat;
    int          exp_lat;
    logic [31:0] e;
    rom_rd  = rd && !wr && !addr[9];
    exp_lat = rom_rd ? 6 : 2;
    re_seen = 0;
    lat     = -1;
    if (rd && !wr) begin
      if (rom_rd) exp_q.push_back(rom_word(addr[8:2]));
      else        exp_q.push_back({27'd0, io_model});
    end
    if (wr && addr[9]) io_model = wd[4:0];
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_data_write = wd;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (rom_rd && k >= 1 && k <= 4) begin
        check("rom_addr", {23'd0, rom_addr}, {23'd0, addr[8:2], 2'(k - 1)});
        check("rom_re", {31'd0, rom_re}, 32'd1);
      end
      if (!rom_rd && rom_re) re_seen = 1;
      if (mem_done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_latency", lat, exp_lat);
    if (rd && !wr) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (lat >= 0) check("read_data", mem_data_read, e);
        last_read = e;
      end
    end else begin
      check("data_held", mem_data_read, last_read);
    end
    check("io_out", {27'd0, io_out}, {27'd0, io_model});
    if (!rom_rd) check("rom_re_quiet", {31'd0, re_seen}, 32'd0);
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, mem_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_read(input logic [9:0] addr);
    int done_cnt;
    mem_read = 1; mem_write = 0; mem_addr = addr;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    reset = 1; mem_read = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rst_done", {31'd0, mem_done}, 32'd0);
    check("rst_data", mem_data_read, 32'd0);
    check("rst_rom_re", {31'd0, rom_re}, 32'd0);
    check("rst_io", {27'd0, io_out}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_done) done_cnt++;
    end
    check("rst_no_done", done_cnt, 0);
    last_read = 0;
    io_model  = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 512; a++) rom[a] = 8'(a * 7 + 3);
    rom[0] = 8'h0B; rom[1] = 8'hAD; rom[2] = 8'hF0; rom[3] = 8'h0D;
    reset = 1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_data_write = '0;
    last_read = 0; io_model = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", mem_data_read, 32'd0);
    check("reset_done", {31'd0, mem_done}, 32'd0);
    check("reset_io", {27'd0, io_out}, 32'd0);
    check("reset_rom_re", {31'd0, rom_re}, 32'd0);
    check("reset_rom_addr", {23'd0, rom_addr}, 32'd0);
    reset = 0;

    access(1, 0, 10'h000, 32'h0);
    access(1, 0, 10'h1FF, 32'h0);
    access(0, 1, 10'h200, 32'h0000_001F);
    access(1, 0, 10'h200, 32'h0);
    access(1, 1, 10'h204, 32'h0000_0015);
    access(0, 1, 10'h010, 32'hFFFF_FFFF);
    access(1, 0, 10'h204, 32'h0);
    reset_mid_read(10'h008);
    access(1, 0, 10'h008, 32'h0);
    for (int n = 0; n < 6; n++) begin
      access(1, 0, 10'($urandom_range(0, 511)), 32'h0);
      access(0, 1, 10'h200 | 10'($urandom_range(0, 511)), $urandom);
    end
    access(1, 0, 10'h3FC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
